// File: rtl/divider_pipelined_pkg.sv
// Shared types for divider_pipelined: default parameters, per-stage state struct, overflow test.
// Signed fields exist only when DIVIDER_SIGNED_EN is defined.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_STAGES = 8;
    localparam int DIV_TAG_W  = 5;
    localparam int DIV_REM_W  = DIV_WIDTH + 1;

    // The struct is sized here, so a different WIDTH/TAG_W build changes these values.
    typedef struct packed {
        logic                  valid;
        logic [DIV_TAG_W-1:0]  tag;
`ifdef DIVIDER_SIGNED_EN
        logic                  isSigned;
        logic                  negQ;
        logic                  negR;
        logic                  ovf;
`endif
        logic                  divZero;
        logic [DIV_WIDTH-1:0]  divisor;
        logic [DIV_REM_W-1:0]  rem;
        logic [DIV_WIDTH-1:0]  quo;
        logic [DIV_WIDTH-1:0]  dvd;
        logic [DIV_WIDTH-1:0]  origDvd;
    } div_state_t;

    function automatic logic is_signed_overflow(input logic [DIV_WIDTH-1:0] dividend,
                                                input logic [DIV_WIDTH-1:0] divisor);
        return (dividend == {1'b1, {(DIV_WIDTH-1){1'b0}}}) && (divisor == {DIV_WIDTH{1'b1}});
    endfunction

endpackage

// File: rtl/divider_pipelined_if.sv
// Issue/result bundle for divider_pipelined; the issuer uses master, the divider slave.
// Identical with or without DIVIDER_SIGNED_EN.
interface divider_pipelined_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH,
    parameter int TAG_W = div_pkg::DIV_TAG_W
);
    logic             i_stall;
    logic             i_valid;
    logic             i_signed;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic [TAG_W-1:0] o_tag;

    modport master (
        output i_stall, i_valid, i_signed, i_dividend, i_divisor, i_tag,
        input  o_valid, o_quotient, o_remainder, o_tag
    );

    modport slave (
        input  i_stall, i_valid, i_signed, i_dividend, i_divisor, i_tag,
        output o_valid, o_quotient, o_remainder, o_tag
    );
endinterface

// File: rtl/divider_pipelined_stage.sv
// div_stage: K combinational restoring shift-subtract iterations on one stage state.
// Unaffected by DIVIDER_SIGNED_EN; sign handling lives at pipe entry and exit.
module div_stage
    import div_pkg::*;
#(
    parameter int K = 4
) (
    input  div_state_t i_state,
    output div_state_t o_state
);

    div_state_t w_work;

    always_comb begin
        w_work = i_state;
        for (int k = 0; k < K; k++) begin
            w_work.rem = {w_work.rem[DIV_WIDTH-1:0], w_work.dvd[DIV_WIDTH-1]};
            if (w_work.rem >= {1'b0, w_work.divisor}) begin
                w_work.rem = w_work.rem - {1'b0, w_work.divisor};
                w_work.quo = {w_work.quo[DIV_WIDTH-2:0], 1'b1};
            end else begin
                w_work.quo = {w_work.quo[DIV_WIDTH-2:0], 1'b0};
            end
            w_work.dvd = {w_work.dvd[DIV_WIDTH-2:0], 1'b0};
        end
    end

    assign o_state = w_work;

endmodule

// File: rtl/divider_pipelined.sv
// Fully pipelined restoring divider, one op per cycle, STAGES cycles of latency.
// Define DIVIDER_SIGNED_EN to honour i_signed (RISC-V DIV/REM semantics); otherwise all ops are unsigned.
module divider_pipelined
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int STAGES = DIV_STAGES,
    parameter int TAG_W  = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    divider_pipelined_if.slave bus
);

    localparam int K    = WIDTH / STAGES;
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

    div_state_t       w_entry;
    div_state_t       w_stageIn  [STAGES];
    div_state_t       w_stageOut [STAGES];
    div_state_t       r_pipe     [NREG];
    div_state_t       w_last;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic             r_valid;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [TAG_W-1:0] r_tag;
    logic             w_unused;

    // Operands become magnitudes here; the special cases are flagged before any iteration.
    always_comb begin
        w_entry          = '0;
        w_entry.valid    = bus.i_valid;
        w_entry.tag      = bus.i_tag;
        w_entry.divZero  = (bus.i_divisor == '0);
        w_entry.origDvd  = bus.i_dividend;
        w_entry.dvd      = bus.i_dividend;
        w_entry.divisor  = bus.i_divisor;
`ifdef DIVIDER_SIGNED_EN
        w_entry.isSigned = bus.i_signed;
        if (bus.i_signed) begin
            w_entry.negQ = bus.i_dividend[WIDTH-1] ^ bus.i_divisor[WIDTH-1];
            w_entry.negR = bus.i_dividend[WIDTH-1];
            w_entry.ovf  = is_signed_overflow(bus.i_dividend, bus.i_divisor);
            if (bus.i_dividend[WIDTH-1]) w_entry.dvd = -bus.i_dividend;
            if (bus.i_divisor[WIDTH-1])  w_entry.divisor = -bus.i_divisor;
        end
`endif
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign w_stageIn[s] = w_entry;
        end else begin : g_rest
            assign w_stageIn[s] = r_pipe[s-1];
        end
        div_stage #(.K(K)) u_stage (
            .i_state (w_stageIn[s]),
            .o_state (w_stageOut[s])
        );
    end

    assign w_last = w_stageOut[STAGES-1];

    // Divide-by-zero is applied last so it wins over the sign fixups in both modes.
    always_comb begin
        w_quo = w_last.quo;
        w_rem = w_last.rem[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
        if (w_last.isSigned) begin
            if (w_last.negQ) w_quo = -w_last.quo;
            if (w_last.negR) w_rem = -w_last.rem[WIDTH-1:0];
            if (w_last.ovf) begin
                w_quo = w_last.origDvd;
                w_rem = '0;
            end
        end
`endif
        if (w_last.divZero) begin
            w_quo = '1;
            w_rem = w_last.origDvd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NREG; s++) r_pipe[s].valid <= 1'b0;
            r_valid <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_tag   <= '0;
        end else if (!bus.i_stall) begin
            for (int s = 0; s < STAGES - 1; s++) r_pipe[s] <= w_stageOut[s];
            r_valid <= w_last.valid;
            r_quo   <= w_quo;
            r_rem   <= w_rem;
            r_tag   <= w_last.tag;
        end
    end

    assign bus.o_valid     = r_valid;
    assign bus.o_quotient  = r_quo;
    assign bus.o_remainder = r_rem;
    assign bus.o_tag       = r_tag;

`ifdef DIVIDER_SIGNED_EN
    assign w_unused = &{1'b0, w_last.rem[WIDTH], w_last.dvd};
`else
    assign w_unused = &{1'b0, w_last.rem[WIDTH], w_last.dvd, bus.i_signed};
`endif

endmodule

// File: tb/tb_divider_pipelined.sv
// Self-checking bench for divider_pipelined against an arithmetic reference model.
// Expected values follow DIVIDER_SIGNED_EN the same way the design does.
module tb_divider_pipelined;
    import div_pkg::*;

    localparam int W   = DIV_WIDTH;
    localparam int STG = DIV_STAGES;
    localparam int TW  = DIV_TAG_W;

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic          sgn;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
    } case_t;

    logic clk = 1'b0;
    logic rst;
    int   passCount  = 0;
    int   checkCount = 0;
    exp_t expQueue[$];

    always #5 clk = ~clk;

    divider_pipelined_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    divider_pipelined #(.WIDTH(W), .STAGES(STG), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain SV arithmetic plus the RISC-V special cases.
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TW-1:0] tag);
        exp_t e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic s;
        s = sgn;
`ifndef DIVIDER_SIGNED_EN
        s = 1'b0;
`endif
        sa = a;
        sb = b;
        e.tag = tag;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (s && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            e.q = a;
            e.r = '0;
        end else if (s) begin
            e.q = sa / sb;
            e.r = sa % sb;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] t);
        bus.i_valid    = v;
        bus.i_signed   = s;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_tag      = t;
    endtask

    // Issues one op into an idle pipe and samples the result after exactly STG edges.
    task automatic runOne(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t, output logic early, output logic vld,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic [TW-1:0] tg);
        early = 1'b0;
        applyStimulus(1'b1, s, a, b, t);
        for (int i = 1; i <= STG; i++) begin
            tick();
            if (i == 1) applyStimulus(1'b0, 1'b0, '0, '0, '0);
            if (i < STG && bus.o_valid) early = 1'b1;
        end
        vld = bus.o_valid;
        q   = bus.o_quotient;
        r   = bus.o_remainder;
        tg  = bus.o_tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_stall = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd3, 5'd1);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkCount++;
        if (bus.o_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.o_valid);
        else passCount++;
        checkCount++;
        if (bus.o_quotient !== '0) $display("[TB] FAIL reset_quotient: got %h expected 0", bus.o_quotient);
        else passCount++;
        checkCount++;
        if (bus.o_remainder !== '0) $display("[TB] FAIL reset_remainder: got %h expected 0", bus.o_remainder);
        else passCount++;
        checkCount++;
        if (bus.o_tag !== '0) $display("[TB] FAIL reset_tag: got %h expected 0", bus.o_tag);
        else passCount++;
    endtask

    task automatic test_directed();
        case_t cases[9];
        logic early, vld;
        logic [W-1:0] q, r;
        logic [TW-1:0] tg;
        cases[0] = '{1'b0, 32'd100,       32'd7,       5'd3,  32'd14,       32'd2};
        cases[2] = '{1'b0, 32'hFFFFFFF9,  32'd2,       5'd7,  32'h7FFFFFFC, 32'd1};
        cases[3] = '{1'b1, 32'd1234,      32'd0,       5'd8,  32'hFFFFFFFF, 32'd1234};
        cases[4] = '{1'b0, 32'd1234,      32'd0,       5'd9,  32'hFFFFFFFF, 32'd1234};
        cases[8] = '{1'b1, 32'hFFFFFFF9,  32'd0,       5'd13, 32'hFFFFFFFF, 32'hFFFFFFF9};
`ifdef DIVIDER_SIGNED_EN
        cases[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,       5'd6,  32'hFFFFFFFD, 32'hFFFFFFFF};
        cases[5] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 5'd10, 32'h80000000, 32'd0};
        cases[6] = '{1'b1, 32'd7,         32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 32'd1};
        cases[7] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 5'd12, 32'd3,        32'hFFFFFFFF};
`else
        cases[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,       5'd6,  32'h7FFFFFFC, 32'd1};
        cases[5] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 5'd10, 32'd0,        32'h80000000};
        cases[6] = '{1'b1, 32'd7,         32'hFFFFFFFE, 5'd11, 32'd0,        32'd7};
        cases[7] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 5'd12, 32'd0,        32'hFFFFFFF9};
`endif
        for (int i = 0; i < 9; i++) begin
            runOne(cases[i].sgn, cases[i].a, cases[i].b, cases[i].tag, early, vld, q, r, tg);
            checkCount++;
            if (early !== 1'b0) $display("[TB] FAIL directed%0d_early_valid: got %b expected 0", i, early);
            else passCount++;
            checkCount++;
            if (vld !== 1'b1) $display("[TB] FAIL directed%0d_valid: got %b expected 1", i, vld);
            else passCount++;
            checkCount++;
            if (q !== cases[i].q) $display("[TB] FAIL directed%0d_quotient: got %h expected %h", i, q, cases[i].q);
            else passCount++;
            checkCount++;
            if (r !== cases[i].r) $display("[TB] FAIL directed%0d_remainder: got %h expected %h", i, r, cases[i].r);
            else passCount++;
            checkCount++;
            if (tg !== cases[i].tag) $display("[TB] FAIL directed%0d_tag: got %h expected %h", i, tg, cases[i].tag);
            else passCount++;
        end
    endtask

    // 20 random ops back to back with alternating sign mode and a 3-cycle stall mid-stream.
    task automatic test_back_to_back();
        int   issued  = 0;
        int   got     = 0;
        bit   haveLast = 1'b0;
        bit   stalled;
        exp_t lastExp;
        exp_t e;
        logic s;
        logic [W-1:0] a, b;
        logic [TW-1:0] t;
        expQueue.delete();
        lastExp = '{'0, '0, '0};
        for (int c = 0; c < 23 + STG + 4; c++) begin
            stalled = (c >= 10 && c < 13);
            bus.i_stall = stalled;
            if (stalled) begin
                applyStimulus(1'b1, 1'b1, $urandom, $urandom, 5'h1F);
            end else if (issued < 20) begin
                s = issued[0];
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 200);
                if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 9);
                if ($urandom_range(0, 9) == 0) b = '1;
                t = issued[TW-1:0];
                applyStimulus(1'b1, s, a, b, t);
                expQueue.push_back(model(s, a, b, t));
                issued++;
            end else begin
                applyStimulus(1'b0, 1'b0, '0, '0, '0);
            end
            tick();
            if (stalled && haveLast) begin
                checkCount++;
                if (bus.o_valid !== 1'b1) $display("[TB] FAIL stall_valid c%0d: got %b expected 1", c, bus.o_valid);
                else passCount++;
                checkCount++;
                if (bus.o_quotient !== lastExp.q || bus.o_remainder !== lastExp.r || bus.o_tag !== lastExp.tag)
                    $display("[TB] FAIL stall_hold c%0d: got q=%h r=%h tag=%h expected q=%h r=%h tag=%h",
                             c, bus.o_quotient, bus.o_remainder, bus.o_tag, lastExp.q, lastExp.r, lastExp.tag);
                else passCount++;
            end else if (!stalled && bus.o_valid) begin
                checkCount++;
                if (expQueue.size() == 0) begin
                    $display("[TB] FAIL b2b_extra c%0d: got unexpected o_valid tag=%h expected none", c, bus.o_tag);
                end else begin
                    passCount++;
                    e = expQueue.pop_front();
                    got++;
                    checkCount++;
                    if (bus.o_quotient !== e.q) $display("[TB] FAIL b2b_quotient tag%0d: got %h expected %h", e.tag, bus.o_quotient, e.q);
                    else passCount++;
                    checkCount++;
                    if (bus.o_remainder !== e.r) $display("[TB] FAIL b2b_remainder tag%0d: got %h expected %h", e.tag, bus.o_remainder, e.r);
                    else passCount++;
                    checkCount++;
                    if (bus.o_tag !== e.tag) $display("[TB] FAIL b2b_tag: got %h expected %h", bus.o_tag, e.tag);
                    else passCount++;
                    lastExp  = e;
                    haveLast = 1'b1;
                end
            end
        end
        bus.i_stall = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkCount++;
        if (got !== 20 || expQueue.size() != 0)
            $display("[TB] FAIL b2b_count: got %0d results (%0d pending) expected 20 (0 pending)", got, expQueue.size());
        else passCount++;
    endtask

    task automatic test_reset_inflight();
        logic early, vld;
        logic [W-1:0] q, r;
        logic [TW-1:0] tg;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i[0], $urandom, $urandom | 32'd1, 5'(i));
            tick();
        end
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 5'd7);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < STG + 2; i++) begin
            checkCount++;
            if (bus.o_valid !== 1'b0) $display("[TB] FAIL flush_valid cycle%0d: got %b expected 0", i, bus.o_valid);
            else passCount++;
            tick();
        end
        runOne(1'b0, 32'd1000, 32'd33, 5'd9, early, vld, q, r, tg);
        checkCount++;
        if (early !== 1'b0 || vld !== 1'b1) $display("[TB] FAIL post_reset_valid: got early=%b valid=%b expected early=0 valid=1", early, vld);
        else passCount++;
        checkCount++;
        if (q !== 32'd30 || r !== 32'd10 || tg !== 5'd9)
            $display("[TB] FAIL post_reset_result: got q=%0d r=%0d tag=%0d expected q=30 r=10 tag=9", q, r, tg);
        else passCount++;
    endtask

    initial begin
        $display("[TB] divider_pipelined WIDTH=%0d STAGES=%0d", W, STG);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
